instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/instr_fetch_pc_next.sv | 23 ++
 rtl/instr_fetch.sv | 106 ++++++++++
 tb/tb_instr_fetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding, instruction geometry and the
// canonical NOP used to fill the instruction register out of reset.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  // A fetch target is legal only on a whole-instruction boundary.
  function automatic logic is_aligned(input logic [15:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection for the fetch stage: redirect target beats sequential
// advance, which beats holding the current PC.
module fetch_pc_next
  import instr_fetch_pkg::*;
(
  input  logic [15:0] pc_in,
  input  logic        advance_in,
  input  logic        redirect_in,
  input  logic [15:0] redirect_pc_in,
  output logic [15:0] pc_next_out
);

  always_comb begin
    pc_next_out = pc_in;
    if (redirect_in) begin
      pc_next_out = redirect_pc_in;
    end else if (advance_in) begin
      // 16-bit modulo: 0xFFFC rolls over to 0x0000 silently.
      pc_next_out = pc_in + 16'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Single-issue instruction fetch stage: one-cycle ROM fetch into a holding
// register with valid/ready handshake, redirect flush and misalignment fault.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rom_addr_out,
  input  logic [31:0] rom_data_in,
  input  logic        redirect_in,
  input  logic [15:0] redirect_pc_in,
  output logic [31:0] instr_out,
  output logic [15:0] pc_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        fault_out
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [15:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;
  logic         advance;

  fetch_pc_next u_pc_next (
    .pc_in          (pc_q),
    .advance_in     (advance),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .pc_next_out    (pc_d)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    advance  = 1'b0;

    // A redirect overrides every state; a concurrent handshake still completes
    // because the consumer already sampled instr_out this cycle.
    if (redirect_in) begin
      valid_d = 1'b0;
      if (is_aligned(redirect_pc_in)) begin
        state_d = ST_FETCH;
        fault_d = 1'b0;
      end else begin
        state_d  = ST_FAULT;
        fault_d  = 1'b1;
        pc_out_d = redirect_pc_in;
      end
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (!valid_q || ready_in) begin
            advance  = 1'b1;
            instr_d  = rom_data_in;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_BOOT;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  // ROM address comes straight from the PC register: no input-to-address path.
  assign rom_addr_out = pc_q;
  assign instr_out    = instr_q;
  assign pc_out       = pc_out_q;
  assign valid_out    = valid_q;
  assign fault_out    = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// handshake/redirect traffic, all compared against a behavioural fetch model.
module tb_instr_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [31:0] instr;
  logic [15:0] pc_o;
  logic        valid;
  logic        ready = 1'b0;
  logic        fault;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic        m_boot;
  logic        m_fault;
  logic        m_valid;
  logic [15:0] m_pc;
  logic [15:0] m_out_pc;
  logic [31:0] m_instr;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction

  assign rom_data = rom_word(rom_addr);

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr_out   (rom_addr),
    .rom_data_in    (rom_data),
    .redirect_in    (redirect),
    .redirect_pc_in (redirect_pc),
    .instr_out      (instr),
    .pc_out         (pc_o),
    .valid_out      (valid),
    .ready_in       (ready),
    .fault_out      (fault)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_boot   = 1'b1;
    m_fault  = 1'b0;
    m_valid  = 1'b0;
    m_pc     = RST_PC;
    m_out_pc = RST_PC;
    m_instr  = NOP;
  endtask

  // One rising edge of the fetch stage described at transaction level.
  task automatic m_step();
    if (redirect) begin
      m_pc    = redirect_pc;
      m_valid = 1'b0;
      m_boot  = 1'b0;
      if (redirect_pc % 4 != 0) begin
        m_fault  = 1'b1;
        m_out_pc = redirect_pc;
      end else begin
        m_fault = 1'b0;
      end
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_fault && (!m_valid || ready)) begin
      m_instr  = rom_word(m_pc);
      m_out_pc = m_pc;
      m_valid  = 1'b1;
      m_pc     = 16'((32'(m_pc) + 4) % 65536);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(m_pc));
    chk({tag, ".instr"},    instr,         m_instr);
    chk({tag, ".pc_out"},   32'(pc_o),     32'(m_out_pc));
    chk({tag, ".valid"},    32'(valid),    32'(m_valid));
    chk({tag, ".fault"},    32'(fault),    32'(m_fault));
  endtask

  task automatic cyc(input logic rd, input logic [15:0] rpc, input logic rdy, input string tag);
    redirect    = rd;
    redirect_pc = rpc;
    ready       = rdy;
    @(posedge clk);
    m_step();
    #1;
    check_all(tag);
  endtask

  // Reset is raised between edges and must take effect without a clock.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk({tag, ".rst_valid"}, 32'(valid),    32'd0);
    chk({tag, ".rst_fault"}, 32'(fault),    32'd0);
    chk({tag, ".rst_instr"}, instr,         NOP);
    chk({tag, ".rst_pc"},    32'(pc_o),     32'(RST_PC));
    chk({tag, ".rst_addr"},  32'(rom_addr), 32'(RST_PC));
    redirect = 1'b0;
    ready    = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    m_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Sequential fetch after reset release
    cyc(1'b0, 16'h0000, 1'b1, "boot");
    chk("boot_valid", 32'(valid), 32'd0);
    cyc(1'b0, 16'h0000, 1'b1, "seq0");
    chk("seq0_pc", 32'(pc_o), 32'h0000);
    cyc(1'b0, 16'h0000, 1'b1, "seq1");
    cyc(1'b0, 16'h0000, 1'b1, "seq2");
    chk("seq2_pc", 32'(pc_o), 32'h0008);
    chk("seq2_instr", instr, rom_word(16'h0008));

    // Stall for three cycles
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b0, "stall");
    chk("stall_pc", 32'(pc_o), 32'h0008);
    chk("stall_addr", 32'(rom_addr), 32'h000C);
    cyc(1'b0, 16'h0000, 1'b1, "unstall");
    chk("unstall_pc", 32'(pc_o), 32'h000C);

    // Redirect with a completing handshake
    cyc(1'b1, 16'h0100, 1'b1, "redir");
    chk("redir_valid", 32'(valid), 32'd0);
    chk("redir_addr", 32'(rom_addr), 32'h0100);
    cyc(1'b0, 16'h0000, 1'b1, "redir_fetch");
    chk("redir_fetch_pc", 32'(pc_o), 32'h0100);

    // Misaligned redirect, held fault, recovery
    cyc(1'b1, 16'h0102, 1'b1, "fault");
    chk("fault_flag", 32'(fault), 32'd1);
    cyc(1'b0, 16'h0000, 1'b1, "fault_hold0");
    cyc(1'b0, 16'h0000, 1'b1, "fault_hold1");
    chk("fault_hold_pc", 32'(pc_o), 32'h0102);
    cyc(1'b1, 16'h0301, 1'b1, "fault_mis");
    chk("fault_mis_pc", 32'(pc_o), 32'h0301);
    cyc(1'b1, 16'h0200, 1'b1, "fault_exit");
    chk("fault_exit_flag", 32'(fault), 32'd0);
    cyc(1'b0, 16'h0000, 1'b1, "fault_exit_fetch");
    chk("fault_exit_pc", 32'(pc_o), 32'h0200);

    // Wrap at top of address space
    cyc(1'b1, 16'hFFFC, 1'b1, "wrap_redir");
    cyc(1'b0, 16'h0000, 1'b1, "wrap0");
    chk("wrap0_pc", 32'(pc_o), 32'hFFFC);
    cyc(1'b0, 16'h0000, 1'b1, "wrap1");
    chk("wrap1_pc", 32'(pc_o), 32'h0000);
    chk("wrap1_fault", 32'(fault), 32'd0);

    // Reset in the middle of a stall
    cyc(1'b1, 16'h0040, 1'b1, "r40");
    cyc(1'b0, 16'h0000, 1'b0, "r40_fetch");
    cyc(1'b0, 16'h0000, 1'b0, "r40_stall");
    chk("r40_pc", 32'(pc_o), 32'h0040);
    mid_reset("stall_rst");

    // Redirects during BOOT
    cyc(1'b1, 16'h0081, 1'b1, "boot_mis");
    chk("boot_mis_fault", 32'(fault), 32'd1);
    mid_reset("fault_rst");
    cyc(1'b1, 16'h0080, 1'b0, "boot_al");
    cyc(1'b0, 16'h0000, 1'b0, "boot_al_fetch");
    chk("boot_al_pc", 32'(pc_o), 32'h0080);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] rpc;
      logic        rd;
      rpc = 16'($urandom);
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      rd = ($urandom_range(7) == 0);
      if ($urandom_range(149) == 0) mid_reset("rand_rst");
      else cyc(rd, rpc, 1'($urandom_range(1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
